mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 23 ++
 rtl/mem_responder_io_fifo.sv | 80 ++++++++
 rtl/mem_responder.sv | 122 ++++++++++++
 tb/tb_mem_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_pkg
// Description : Shared constants and helpers for the memory responder: IO
//               base address, status register offset and region decode.
//               Optional feature macro used by mem_responder:
//               MEM_RESP_IO_STATUS_EN (FIFO count readable at IO_BASE+4).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    // IO space lives where mem_addr[17:16] == 2'b11
    localparam logic [1:0]  c_IO_REGION     = 2'b11;
    localparam logic [31:0] c_IO_BASE       = 32'h0003_0000;
    localparam logic [31:0] c_IO_STATUS_OFF = 32'd4;

    // Region decode works on the two region bits only
    function automatic logic is_io_region(input logic [1:0] region_bits);
        return (region_bits == c_IO_REGION);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_io_fifo.sv
`default_nettype none
// ============================================================================
// Module      : io_fifo
// Description : Output byte FIFO for the IO transmit path. Register-based
//               storage, head entry presented combinationally from the
//               registered array/pointer, so dout is valid the cycle after
//               a push into an empty FIFO.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               push, din  - enqueue request and data
//               pop        - dequeue request (ignored when empty)
//               dout       - head entry
//               count      - occupancy, $clog2(DEPTH)+1 bits
//               full/empty - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module io_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [7:0]         r_mem [0:DEPTH-1];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = pop & ~empty;
    // A push into a full FIFO is still accepted if a pop frees the slot
    // in the same cycle; otherwise it is dropped.
    assign w_do_push = push & (~full | w_do_pop);

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rptr];
    assign count = r_count;
    assign full  = (r_count == c_CNT_W'(DEPTH));
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Byte-wide memory responder. Serves RAM reads/writes with
//               1-cycle read latency and maps a small IO space whose data
//               register (IO_BASE) feeds an output FIFO drained via a
//               valid/ready handshake.
//               Optional macro MEM_RESP_IO_STATUS_EN: a read of IO_BASE+4
//               returns the FIFO count; otherwise it reads as 8'h00.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               rdy               - global enable for the CPU side
//               mem_addr/dout/rw  - initiator address, write byte, access type
//               mem_din           - registered read byte
//               io_buffer_full    - FIFO holds DEPTH-1 or more entries
//               tx_data/valid     - FIFO head and non-empty flag
//               tx_ready          - downstream accepts tx_data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] mem_addr,
    input  logic [7:0]  mem_dout,
    input  logic        mem_rw,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]            r_ram [0:(2**ADDR_WIDTH)-1];
    logic [7:0]            r_mem_din;

    logic                  w_is_io;
    logic [ADDR_WIDTH-1:0] w_ram_idx;
    logic                  w_ram_we;
    logic                  w_rd_en;
    logic                  w_push;
    logic                  w_pop;
    logic [7:0]            w_io_rdata;
    logic [c_CNT_W-1:0]    w_count;
    logic                  w_full;
    logic                  w_empty;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_is_io   = is_io_region(mem_addr[17:16]);
    assign w_ram_idx = mem_addr[ADDR_WIDTH-1:0];
    assign w_ram_we  = rdy & mem_rw & ~w_is_io & ~rst;
    assign w_rd_en   = rdy & ~mem_rw;
    // Only the exact data-register address enqueues; other IO writes vanish.
    assign w_push    = rdy & mem_rw & (mem_addr == c_IO_BASE) & ~rst;
    // Draining is a sink-side handshake and ignores rdy.
    assign w_pop     = tx_valid & tx_ready;

    // ------------------------------------------------------------------
    // IO read data
    // ------------------------------------------------------------------
`ifdef MEM_RESP_IO_STATUS_EN
    always_comb begin
        w_io_rdata = 8'h00;
        if (mem_addr == (c_IO_BASE + c_IO_STATUS_OFF)) begin
            w_io_rdata[c_CNT_W-1:0] = w_count;
        end
    end
`else
    assign w_io_rdata = 8'h00;
`endif

    // ------------------------------------------------------------------
    // RAM: contents survive reset. A read in the cycle after a write sees
    // the new byte because the write lands at the earlier edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_idx] <= mem_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_din <= 8'h00;
        end else if (w_rd_en) begin
            r_mem_din <= w_is_io ? w_io_rdata : r_ram[w_ram_idx];
        end
    end

    assign mem_din = r_mem_din;

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    io_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_io_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (mem_dout),
        .dout  (tx_data),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign tx_valid       = ~w_empty;
    // One slot of headroom for a write already in flight.
    assign io_buffer_full = (w_count >= c_CNT_W'(FIFO_DEPTH - 1));

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder. A behavioural model
//               (associative byte array for RAM, queue for the output FIFO)
//               predicts mem_din, tx_valid, tx_data and io_buffer_full
//               after every clock; directed scenarios are followed by a
//               randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int          c_DEPTH   = 8;
    localparam logic [31:0] c_IO_BASE = 32'h0003_0000;
    localparam logic [31:0] c_IO_STAT = 32'h0003_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_rw;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] ram_m [int];
    logic [7:0] q [$];
    logic [7:0] exp_din;
    int         wr_list [$];

    mem_responder #(
        .ADDR_WIDTH (17),
        .FIFO_DEPTH (c_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .mem_addr       (mem_addr),
        .mem_dout       (mem_dout),
        .mem_rw         (mem_rw),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] io_read_val(input logic [31:0] a);
`ifdef MEM_RESP_IO_STATUS_EN
        if (a == c_IO_STAT) return 8'(q.size());
`endif
        return 8'h00;
    endfunction

    // One clock: apply inputs, advance the model, compare after the edge.
    task automatic step(input logic r, input logic w, input logic [31:0] a,
                        input logic [7:0] d, input logic t);
        bit io, pop, push;
        rdy = r; mem_rw = w; mem_addr = a; mem_dout = d; tx_ready = t;
        io = (a[17:16] == 2'b11);
        if (rst) begin
            q.delete();
            exp_din = 8'h00;
        end else begin
            pop  = t && (q.size() != 0);
            push = r && w && (a == c_IO_BASE) && (q.size() < c_DEPTH || pop);
            if (r && !w) exp_din = io ? io_read_val(a) : ram_m[int'(a[16:0])];
            if (r && w && !io) begin
                ram_m[int'(a[16:0])] = d;
                wr_list.push_back(int'(a[16:0]));
            end
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(d);
        end
        @(posedge clk);
        #1;
        chk("mem_din", {24'h0, mem_din}, {24'h0, exp_din});
        chk("tx_valid", {31'h0, tx_valid}, {31'h0, q.size() != 0});
        chk("io_buffer_full", {31'h0, io_buffer_full},
            {31'h0, q.size() >= c_DEPTH - 1});
        if (q.size() != 0) chk("tx_data", {24'h0, tx_data}, {24'h0, q[0]});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        // Push attempt during reset must be ignored
        step(1'b1, 1'b1, c_IO_BASE, 8'hEE, 1'b0);
        step(1'b1, 1'b1, c_IO_BASE, 8'hEF, 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  exp_status;
        int          sel;

        rst = 1'b1; rdy = 1'b0; mem_rw = 1'b0; mem_addr = '0;
        mem_dout = '0; tx_ready = 1'b0; exp_din = 8'h00;

        // Reset state
        do_reset();
        chk("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("reset_mem_din", {24'h0, mem_din}, 32'h0);

        // Write A5 then read it back next cycle
        step(1'b1, 1'b1, 32'h0001_0, 8'hA5, 1'b0);
        step(1'b1, 1'b0, 32'h0001_0, 8'h00, 1'b0);
        chk("rd_a5", {24'h0, mem_din}, 32'hA5);

        // Four sequential writes then reads
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 32'h100 + i, 8'h11 * (i + 1), 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h100 + i, 8'h00, 1'b0);
            chk("seq_rd", {24'h0, mem_din}, 32'h11 * (i + 1));
        end

        // Upper RAM half and other-IO write/read are harmless
        step(1'b1, 1'b1, 32'h0001_FFFF, 8'h3C, 1'b0);
        step(1'b1, 1'b1, 32'h0003_0008, 8'h77, 1'b0);
        step(1'b1, 1'b0, 32'h0001_FFFF, 8'h00, 1'b0);
        step(1'b1, 1'b0, c_IO_BASE, 8'h00, 1'b0);
        chk("io_base_rd", {24'h0, mem_din}, 32'h0);

        // Fill with tx_ready low: 9 writes, the 9th is dropped
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, c_IO_BASE, 8'hC0 + i, 1'b0);
            if (i == 5) chk("not_full_after_6", {31'h0, io_buffer_full}, 32'h0);
            if (i == 6) chk("full_after_7", {31'h0, io_buffer_full}, 32'h1);
        end
        chk("count_8", q.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", {24'h0, tx_data}, 32'hC0 + i);
            step(1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
        end
        chk("drained_valid", {31'h0, tx_valid}, 32'h0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b1, c_IO_BASE, 8'h60 + i, 1'b0);
        step(1'b1, 1'b1, c_IO_BASE, 8'h5A, 1'b1);
        chk("full_pushpop_count", q.size(), 32'd8);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
        chk("empty_after_5a", {31'h0, tx_valid}, 32'h0);

        // rdy low: no RAM write, no push, drain continues
        step(1'b1, 1'b1, c_IO_BASE, 8'h91, 1'b0);
        step(1'b1, 1'b1, c_IO_BASE, 8'h92, 1'b0);
        step(1'b0, 1'b1, 32'h0001_0, 8'hFF, 1'b1);
        step(1'b0, 1'b1, c_IO_BASE, 8'hFE, 1'b1);
        chk("rdy0_drained", {31'h0, tx_valid}, 32'h0);
        step(1'b1, 1'b0, 32'h0001_0, 8'h00, 1'b0);
        chk("rdy0_ram_kept", {24'h0, mem_din}, 32'hA5);

        // Reset with three bytes queued; status read before and after
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, c_IO_BASE, 8'hB0 + i, 1'b0);
        step(1'b1, 1'b0, c_IO_STAT, 8'h00, 1'b0);
`ifdef MEM_RESP_IO_STATUS_EN
        exp_status = 8'd3;
`else
        exp_status = 8'd0;
`endif
        chk("status_before_rst", {24'h0, mem_din}, {24'h0, exp_status});
        do_reset();
        chk("rst_mid_drain_valid", {31'h0, tx_valid}, 32'h0);
        step(1'b1, 1'b0, c_IO_STAT, 8'h00, 1'b1);
        chk("status_after_rst", {24'h0, mem_din}, 32'h0);
        step(1'b1, 1'b0, 32'h0001_0, 8'h00, 1'b0);
        chk("ram_survives_rst", {24'h0, mem_din}, 32'hA5);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 30) begin
                step($urandom_range(0, 3) != 0, 1'b1, c_IO_BASE,
                     8'($urandom), $urandom_range(0, 2) == 0);
            end else if (sel < 40) begin
                step($urandom_range(0, 3) != 0, 1'b0, c_IO_STAT, 8'h00,
                     $urandom_range(0, 1) == 1);
            end else if (sel < 45) begin
                a = 32'h0003_0000 | 32'($urandom_range(1, 16'hFFFF));
                step(1'b1, $urandom_range(0, 1) == 1, a, 8'($urandom),
                     $urandom_range(0, 1) == 1);
            end else if (sel < 70) begin
                a = 32'($urandom_range(0, 17'h1FFFF));
                step($urandom_range(0, 3) != 0, 1'b1, a, 8'($urandom),
                     $urandom_range(0, 1) == 1);
            end else begin
                a = 32'(wr_list[$urandom_range(0, wr_list.size() - 1)]);
                step($urandom_range(0, 3) != 0, 1'b0, a, 8'h00,
                     $urandom_range(0, 1) == 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
